// File: rtl/vector_checker.sv
// ---------------------------------------------------------------------------
// vector_checker
//
// Purpose:
//   Response checker for on-chip self-test. Each accepted sample compares a
//   DUT output word with a golden word. The checker counts accepted vectors
//   and mismatches, and it keeps the first failing vector. A run stops after
//   NUM_VECTORS accepted samples, and pass/fail is then reported.
//
// Parameters:
//   WIDTH        width of the compared words
//   NUM_VECTORS  samples per run, 1 .. 2**CNT_W-1
//   CNT_W        width of the vector, error and index counters
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high; clears all state
//   start               begin a run (honoured in IDLE and DONE only)
//   sample_valid        actual/expected are valid this cycle
//   actual              DUT output word
//   expected            golden word
//   busy                1 while a run is in progress
//   done                1 once the run has finished
//   pass                1 in DONE when no mismatch was seen
//   err_pulse           1-cycle pulse after a mismatching sample
//   vector_count        samples accepted in this run
//   error_count         mismatches in this run (saturating)
//   first_err_index     0-based index of the first mismatch
//   first_err_actual    actual word of the first mismatch
//   first_err_expected  expected word of the first mismatch
// ---------------------------------------------------------------------------
module vector_checker #(
  parameter int WIDTH       = 8,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] actual,
  input  logic [WIDTH-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] vector_count,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] first_err_index,
  output logic [WIDTH-1:0] first_err_actual,
  output logic [WIDTH-1:0] first_err_expected
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Value of vector_count on the final sample of a run.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  state_t state;

  logic             accept;
  logic             mismatch;
  logic             last_sample;
  logic             first_mismatch;
  logic [CNT_W-1:0] error_count_inc;

  assign accept      = (state == RUN) && sample_valid;
  assign mismatch    = (actual != expected);
  assign last_sample = (vector_count == LAST_IDX);

  // error_count never leaves zero once it has counted a mismatch, because it
  // saturates and does not wrap. A zero count therefore marks the first
  // mismatch of the run.
  assign first_mismatch = (error_count == '0);

  assign error_count_inc = (error_count == ERR_MAX) ? error_count
                                                    : error_count + 1'b1;

  // The status flags come straight from the state register. Only one of
  // them can be high at a time.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      pass               <= 1'b0;
      err_pulse          <= 1'b0;
      vector_count       <= '0;
      error_count        <= '0;
      first_err_index    <= '0;
      first_err_actual   <= '0;
      first_err_expected <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // No sample is accepted here, so the pulse from a mismatch on the
          // final sample lasts only one cycle.
          err_pulse <= 1'b0;
          // start has priority over a sample in the same cycle. That sample
          // is dropped, and results are held until the next run begins.
          if (start) begin
            state              <= RUN;
            pass               <= 1'b0;
            vector_count       <= '0;
            error_count        <= '0;
            first_err_index    <= '0;
            first_err_actual   <= '0;
            first_err_expected <= '0;
          end
        end

        RUN: begin
          err_pulse <= accept && mismatch;
          if (accept) begin
            vector_count <= vector_count + 1'b1;
            if (mismatch) begin
              error_count <= error_count_inc;
              if (first_mismatch) begin
                first_err_index    <= vector_count;
                first_err_actual   <= actual;
                first_err_expected <= expected;
              end
            end
            // The final sample is still checked, so its own result counts
            // toward pass.
            if (last_sample) begin
              state <= DONE;
              pass  <= !mismatch && (error_count == '0);
            end
          end
        end

        default: begin
          state     <= IDLE;
          err_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_vector_checker
//
// Two checkers share one stimulus stream: inst 0 uses the default
// NUM_VECTORS=4, and inst 1 uses NUM_VECTORS=15 for the saturation case.
// A reference model records each run as a list of accepted (actual,
// expected) pairs. Every output is derived from that list. A compare process
// checks both instances against the model on every falling edge. Literal
// checks pin the headline results of each scenario.
// ---------------------------------------------------------------------------
module tb_vector_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sample_valid;
  logic [7:0] actual;
  logic [7:0] expected;

  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic       pulse_w [2];
  logic [3:0] vc_w    [2];
  logic [3:0] ec_w    [2];
  logic [3:0] fi_w    [2];
  logic [7:0] fa_w    [2];
  logic [7:0] fe_w    [2];

  int n_cmp = 0;
  int n_bad = 0;

  vector_checker #(.WIDTH(8), .NUM_VECTORS(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .actual(actual), .expected(expected),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_pulse(pulse_w[0]),
    .vector_count(vc_w[0]), .error_count(ec_w[0]), .first_err_index(fi_w[0]),
    .first_err_actual(fa_w[0]), .first_err_expected(fe_w[0])
  );

  vector_checker #(.WIDTH(8), .NUM_VECTORS(15), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .actual(actual), .expected(expected),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_pulse(pulse_w[1]),
    .vector_count(vc_w[1]), .error_count(ec_w[1]), .first_err_index(fi_w[1]),
    .first_err_actual(fa_w[1]), .first_err_expected(fe_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // run_state: 0 = idle, 1 = running, 2 = finished
  int         run_state [2];
  int         n_acc     [2];
  bit         pulse_m   [2];
  logic [7:0] acc_a     [2][16];
  logic [7:0] acc_e     [2][16];
  int         n_vec     [2];
  bit         cmp_en = 1'b0;

  initial begin
    n_vec[0] = 4;
    n_vec[1] = 15;
    for (int i = 0; i < 2; i++) begin
      run_state[i] = 0;
      n_acc[i]     = 0;
      pulse_m[i]   = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          run_state[i] = 0;
          n_acc[i]     = 0;
          pulse_m[i]   = 1'b0;
        end else begin
          pulse_m[i] = 1'b0;
          if (run_state[i] != 1) begin
            if (start) begin
              run_state[i] = 1;
              n_acc[i]     = 0;
            end
          end else if (sample_valid) begin
            acc_a[i][n_acc[i]] = actual;
            acc_e[i][n_acc[i]] = expected;
            pulse_m[i] = (actual != expected);
            n_acc[i]++;
            if (n_acc[i] == n_vec[i]) run_state[i] = 2;
          end
        end
      end
    end
  end

  function automatic int m_errs(int i);
    int c = 0;
    for (int j = 0; j < n_acc[i]; j++)
      if (acc_a[i][j] != acc_e[i][j]) c++;
    return (c > 15) ? 15 : c;
  endfunction

  // Index of the first mismatch, or -1 if there is none.
  function automatic int m_first(int i);
    for (int j = 0; j < n_acc[i]; j++)
      if (acc_a[i][j] != acc_e[i][j]) return j;
    return -1;
  endfunction

  task automatic cmp(string name, int i, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[inst%0d] @%0t: got %0h want %0h", name, i, $time, act, exp);
    end
  endtask

  // Compare every output of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        int fi;
        fi = m_first(i);
        cmp("busy",      i, int'(busy_w[i]),  int'(run_state[i] == 1));
        cmp("done",      i, int'(done_w[i]),  int'(run_state[i] == 2));
        cmp("pass",      i, int'(pass_w[i]),  int'(run_state[i] == 2 && m_errs(i) == 0));
        cmp("err_pulse", i, int'(pulse_w[i]), int'(pulse_m[i]));
        cmp("vec_count", i, int'(vc_w[i]),    n_acc[i]);
        cmp("err_count", i, int'(ec_w[i]),    m_errs(i));
        cmp("first_idx", i, int'(fi_w[i]),    (fi < 0) ? 0 : fi);
        cmp("first_act", i, int'(fa_w[i]),    (fi < 0) ? 0 : int'(acc_a[i][fi]));
        cmp("first_exp", i, int'(fe_w[i]),    (fi < 0) ? 0 : int'(acc_e[i][fi]));
      end
    end
  end

  // Count err_pulse cycles on inst 0.
  int pulse_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (cmp_en && pulse_w[0]) pulse_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(string name, int act, int exp);
    cmp(name, 9, act, exp);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sample(logic [7:0] a, logic [7:0] e);
    sample_valid = 1'b1;
    actual       = a;
    expected     = e;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  logic [7:0] clean_v [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
  logic [7:0] err_a   [4] = '{8'h11, 8'h01, 8'h22, 8'hF0};
  logic [7:0] err_e   [4] = '{8'h11, 8'h00, 8'h22, 8'h0F};

  initial begin
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
    actual = '0; expected = '0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    lit("reset_busy",  int'(busy_w[0]), 0);
    lit("reset_done",  int'(done_w[0]), 0);
    lit("reset_pass",  int'(pass_w[0]), 0);
    lit("reset_vc",    int'(vc_w[0]),   0);
    reset = 1'b0;

    // A sample in IDLE is ignored.
    sample(8'h12, 8'h34);
    idle(1);
    lit("idle_ignore_vc", int'(vc_w[0]), 0);

    // Clean run. The start cycle also carries a mismatching sample, which
    // must be dropped.
    pulse_cnt = 0;
    start = 1'b1; sample_valid = 1'b1; actual = 8'h55; expected = 8'hAA;
    @(negedge clk);
    start = 1'b0; sample_valid = 1'b0;
    foreach (clean_v[k]) sample(clean_v[k], clean_v[k]);
    lit("clean_done", int'(done_w[0]), 1);
    lit("clean_pass", int'(pass_w[0]), 1);
    lit("clean_vc",   int'(vc_w[0]),   4);
    lit("clean_ec",   int'(ec_w[0]),   0);
    idle(2);
    lit("clean_pulses", pulse_cnt, 0);

    // Error run. This start restarts inst 0 and is ignored by the running
    // inst 1.
    pulse_cnt = 0;
    do_start();
    foreach (err_a[k]) sample(err_a[k], err_e[k]);
    lit("err_done", int'(done_w[0]), 1);
    lit("err_ec",   int'(ec_w[0]),   2);
    lit("err_fi",   int'(fi_w[0]),   1);
    lit("err_fa",   int'(fa_w[0]),   8'h01);
    lit("err_fe",   int'(fe_w[0]),   8'h00);
    idle(2);
    lit("err_pass",   int'(pass_w[0]), 0);
    lit("err_pulses", pulse_cnt, 2);

    // Run with gaps between samples and a start pulse in the middle.
    do_start();
    idle(1);
    sample(8'h01, 8'h01);
    idle(2);
    do_start();
    sample(8'h02, 8'h02);
    idle(1);
    sample(8'h03, 8'h03);
    lit("gap_busy", int'(busy_w[0]), 1);
    lit("gap_vc3",  int'(vc_w[0]),   3);
    idle(3);
    sample(8'h04, 8'h04);
    lit("gap_vc4",  int'(vc_w[0]),   4);
    lit("gap_done", int'(done_w[0]), 1);
    // A sample in DONE is ignored.
    sample(8'h77, 8'h00);
    idle(1);
    lit("done_ignore_vc", int'(vc_w[0]), 4);
    lit("done_ignore_ec", int'(ec_w[0]), 0);

    // Reset in the middle of a run, then a clean run.
    do_start();
    sample(8'h10, 8'h10);
    sample(8'h20, 8'h21);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lit("midrst_busy", int'(busy_w[0]), 0);
    lit("midrst_ec",   int'(ec_w[0]),   0);
    lit("midrst_vc",   int'(vc_w[0]),   0);
    lit("midrst_fa",   int'(fa_w[0]),   0);
    do_start();
    foreach (clean_v[k]) sample(clean_v[k], clean_v[k]);
    lit("post_rst_pass", int'(pass_w[0]), 1);

    // Saturation on inst 1: 15 mismatches.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_start();
    for (int j = 0; j < 15; j++) sample(8'(j), 8'(j) ^ 8'h80);
    lit("sat_done", int'(done_w[1]), 1);
    lit("sat_ec",   int'(ec_w[1]),   15);
    lit("sat_vc",   int'(vc_w[1]),   15);
    lit("sat_fi",   int'(fi_w[1]),   0);
    idle(1);
    lit("sat_pass", int'(pass_w[1]), 0);
    // Restart from DONE. The counters clear and then count again.
    do_start();
    lit("restart_ec0", int'(ec_w[1]), 0);
    sample(8'h5A, 8'h5B);
    lit("restart_ec1", int'(ec_w[1]), 1);
    lit("restart_vc1", int'(vc_w[1]), 1);
    lit("restart_fa",  int'(fa_w[1]), 8'h5A);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
